// File: rtl/sort_fifo_bank_if.sv
// Per-channel push/pop/flush controls and status for sort_fifo_bank.
// The master side drives the requests; the slave side is the FIFO bank.
interface sort_fifo_bank_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LOG2_DEPTH = 2,
  parameter int unsigned NUM_CH     = 2
);
  logic [NUM_CH-1:0]                  wr_en;
  logic [NUM_CH-1:0]                  rd_en;
  logic [NUM_CH-1:0]                  flush;
  logic [NUM_CH*DATA_WIDTH-1:0]       din;
  logic [NUM_CH*DATA_WIDTH-1:0]       head;
  logic [NUM_CH*(LOG2_DEPTH+1)-1:0]   count;
  logic [NUM_CH-1:0]                  empty;
  logic [NUM_CH-1:0]                  full;
  logic [NUM_CH-1:0]                  almost_full;
  logic [NUM_CH-1:0]                  overflow;
  logic [NUM_CH-1:0]                  underflow;

  modport master (
    output wr_en, rd_en, flush, din,
    input  head, count, empty, full, almost_full, overflow, underflow
  );

  modport slave (
    input  wr_en, rd_en, flush, din,
    output head, count, empty, full, almost_full, overflow, underflow
  );
endinterface

// File: rtl/sort_fifo_bank.sv
// Bank of independent show-ahead FIFOs buffering sorted runs between merge stages.
// Each channel exposes its oldest word on head, occupancy/status, and sticky error flags.
module sort_fifo_bank #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned LOG2_DEPTH      = 2,
  parameter int unsigned NUM_CH          = 2,
  parameter int unsigned ALMOST_FULL_LVL = 2**LOG2_DEPTH - 1
) (
  input logic             clk,
  input logic             reset,
  sort_fifo_bank_if.slave bus
);
  localparam int unsigned     Depth    = 2**LOG2_DEPTH;
  localparam int unsigned     CntW     = LOG2_DEPTH + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);
  localparam logic [CntW-1:0] AfLvl    = CntW'(ALMOST_FULL_LVL);

  logic [DATA_WIDTH-1:0] head_ch  [NUM_CH];
  logic [CntW-1:0]       cnt_ch   [NUM_CH];
  logic                  empty_ch [NUM_CH];
  logic                  full_ch  [NUM_CH];
  logic                  af_ch    [NUM_CH];
  logic                  ovf_ch   [NUM_CH];
  logic                  udf_ch   [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [LOG2_DEPTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  ovf_q, ovf_d, udf_q, udf_d;
    logic [DATA_WIDTH-1:0] mem_q [Depth];
    logic [DATA_WIDTH-1:0] wdata;
    logic                  is_empty, is_full, wr_acc, rd_acc;

    assign wdata    = bus.din[c*DATA_WIDTH +: DATA_WIDTH];
    assign is_empty = (cnt_q == '0);
    assign is_full  = (cnt_q == DepthCnt);
    assign rd_acc   = bus.rd_en[c] & ~bus.flush[c] & ~is_empty;
    // A full channel still takes a push when a pop frees a slot in the same cycle.
    assign wr_acc   = bus.wr_en[c] & ~bus.flush[c] & (~is_full | rd_acc);

    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      ovf_d    = ovf_q;
      udf_d    = udf_q;
      if (bus.flush[c]) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        cnt_d    = '0;
        ovf_d    = 1'b0;
        udf_d    = 1'b0;
      end else begin
        if (wr_acc) wr_ptr_d = wr_ptr_q + LOG2_DEPTH'(1);
        if (rd_acc) rd_ptr_d = rd_ptr_q + LOG2_DEPTH'(1);
        case ({wr_acc, rd_acc})
          2'b10:   cnt_d = cnt_q + CntW'(1);
          2'b01:   cnt_d = cnt_q - CntW'(1);
          default: cnt_d = cnt_q;
        endcase
        if (bus.wr_en[c] && !wr_acc) ovf_d = 1'b1;
        if (bus.rd_en[c] && is_empty) udf_d = 1'b1;
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
        ovf_q    <= 1'b0;
        udf_q    <= 1'b0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        cnt_q    <= cnt_d;
        ovf_q    <= ovf_d;
        udf_q    <= udf_d;
      end
    end

    // Storage is deliberately left out of reset; empty channels mask it on head.
    always_ff @(posedge clk) begin
      if (wr_acc) mem_q[wr_ptr_q] <= wdata;
    end

    assign head_ch[c]  = is_empty ? '0 : mem_q[rd_ptr_q];
    assign cnt_ch[c]   = cnt_q;
    assign empty_ch[c] = is_empty;
    assign full_ch[c]  = is_full;
    assign af_ch[c]    = (cnt_q >= AfLvl);
    assign ovf_ch[c]   = ovf_q;
    assign udf_ch[c]   = udf_q;
  end

  always_comb begin
    bus.head        = '0;
    bus.count       = '0;
    bus.empty       = '0;
    bus.full        = '0;
    bus.almost_full = '0;
    bus.overflow    = '0;
    bus.underflow   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      bus.head[c*DATA_WIDTH +: DATA_WIDTH] = head_ch[c];
      bus.count[c*CntW +: CntW]            = cnt_ch[c];
      bus.empty[c]                         = empty_ch[c];
      bus.full[c]                          = full_ch[c];
      bus.almost_full[c]                   = af_ch[c];
      bus.overflow[c]                      = ovf_ch[c];
      bus.underflow[c]                     = udf_ch[c];
    end
  end
endmodule

// File: doc/sort_fifo_bank.md
# sort_fifo_bank

Parametrised bank of NUM_CH independent synchronous FIFOs. It buffers sorted runs between merge stages of the parallel merge-sort datapath. Each channel exposes a show-ahead head word so the downstream comparator can inspect the next element without popping it. Per-channel full, almost-full and occupancy outputs let upstream stages throttle, and sticky overflow/underflow flags catch protocol errors.

## Interface
- DATA_WIDTH, 32: width of one element.
- LOG2_DEPTH, 2: per-channel depth is 2**LOG2_DEPTH. Must be ≥1.
- NUM_CH, 2: number of independent channels. Must be ≥1.
- ALMOST_FULL_LVL, 2**LOG2_DEPTH-1: occupancy at or above which almost_full asserts. Range 1..2**LOG2_DEPTH.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  NUM_CH  per-channel push request.
- din  in  NUM_CH*DATA_WIDTH  push data; channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
- rd_en  in  NUM_CH  per-channel pop request.
- flush  in  NUM_CH  per-channel synchronous clear.
- head  out  NUM_CH*DATA_WIDTH  oldest stored word per channel, combinational from state; 0 when that channel is empty.
- count  out  NUM_CH*(LOG2_DEPTH+1)  per-channel occupancy, 0..2**LOG2_DEPTH.
- empty, full, almost_full  out  NUM_CH each  per-channel status.
- overflow, underflow  out  NUM_CH each  sticky error flags.

## Operation
- Per channel state: wr_ptr and rd_ptr (LOG2_DEPTH bits, wrap modulo depth), cnt (LOG2_DEPTH+1 bits), storage array, overflow and underflow flags. Channels never interact.
- Status outputs are derived from cnt:
  - empty = (cnt==0).
  - full = (cnt==2**LOG2_DEPTH).
  - almost_full = (cnt ≥ ALMOST_FULL_LVL).
- Push acceptance: wr_acc = wr_en & ~flush & (~full | rd_acc).
- Pop acceptance: rd_acc = rd_en & ~flush & ~empty.
- Full channel with rd_en and wr_en in the same cycle: both are accepted, cnt is unchanged, and the written slot is the one just freed.
- Empty channel with rd_en and wr_en in the same cycle: the pop is rejected and underflow is set. The push is accepted and cnt becomes 1. There is no bypass.
- Rejected push (wr_en while full without an accepted pop): the write is dropped, storage is unchanged and overflow is set.
- Rejected pop (rd_en while empty): pointers are unchanged and underflow is set.
- Accepted push writes din to mem[wr_ptr] and increments wr_ptr. Accepted pop increments rd_ptr. cnt changes by +1, -1 or 0 accordingly.
- head = mem[rd_ptr] when cnt≠0, else 0.
- Flush has priority over wr_en and rd_en in the same cycle. It zeroes wr_ptr, rd_ptr, cnt, overflow and underflow. Storage contents are not cleared.
- Overflow and underflow stay set until reset or flush.
- Reset (reset=0) zeroes all pointers, counts and flags immediately, without waiting for a clock edge. Storage is not reset.
- Reset asserted mid-stream discards all buffered data. The first push after reset is released writes slot 0.

## Timing
- Values while reset is asserted:
  - head=0, count=0, empty=all ones, full=0, almost_full=0.
  - overflow=0, underflow=0.
- Push latency: a word pushed at edge k into an empty channel appears on head, with empty=0, after edge k.
- Pop: an accepted pop at edge k advances head to the next word after edge k. head is valid in the same cycle rd_en is sampled, so a consumer reads head and asserts rd_en together.
- Flags and count update on the same edge as the push or pop that changes them. No extra pipeline stage.
- Pointer wrap: after 2**LOG2_DEPTH accepted pushes, wr_ptr returns to 0 and storage is reused in order.
- Sustained throughput: one push and one pop per channel per cycle, at any occupancy except the empty-pop case above.

## Test plan
Configuration for all scenarios: NUM_CH=2, DATA_WIDTH=8, LOG2_DEPTH=2, ALMOST_FULL_LVL=3.
1. Reset, then push 0x11, 0x22, 0x33, 0x44 on ch0 -> after the 3rd push almost_full[0]=1; after the 4th, full[0]=1 and count[0]=4. Then pop 4 times -> head[0] shows 0x11, 0x22, 0x33, 0x44 in order, then empty[0]=1 and head[0]=0. Ch1 stays empty throughout.
2. Fill ch1 with 0xA0..0xA3, then push 0xFF alone -> overflow[1]=1, count[1]=4, and head[1] stays 0xA0. Then pop and push 0xB0 in the same cycle -> count[1]=4, and the 4 subsequent pops return 0xA1, 0xA2, 0xA3, 0xB0.
3. Empty ch0, assert rd_en and wr_en with din=0x5A in the same cycle -> underflow[0]=1, count[0]=1, head[0]=0x5A on the next cycle.
4. Run 10 interleaved push/pop cycles on ch0 so both pointers wrap twice -> data is returned in FIFO order, with no overflow or underflow.
5. Ch0 holds 3 words with overflow set; assert flush[0] with wr_en[0]=1 -> next cycle count[0]=0, empty[0]=1, overflow[0]=0, and the written word is dropped. Ch1 state is unchanged.
6. Assert reset asynchronously between clock edges while both channels are non-empty -> count=0, empty=all ones and all flags=0 before the next edge. After release, a push of 0x77 followed by a pop returns 0x77.
